// File: rtl/cba_multiword_seq_if.sv
// -----------------------------------------------------------------------------
// cba_multiword_seq_if
// Operand/result handshake bundle for cba_multiword_seq.
//   in_valid / in_ready   : operand request / accept (accept = in_valid && in_ready)
//   in_a, in_b (W bits)   : wide operands
//   in_cin                : initial carry
//   out_valid / out_ready : result available / sink accepts
//   out_sum (W bits)      : wide sum
//   out_cout              : carry out of the MSB
// master = operand source + result sink, slave = the sequencer.
// -----------------------------------------------------------------------------
interface cba_multiword_seq_if #(
   parameter int W = 64
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/cba_multiword_seq.sv
// -----------------------------------------------------------------------------
// cba_multiword_seq
// Runs one external WORD_W-bit carry-bypass adder over a W = WORD_W*NUM_WORDS
// bit operand pair, least significant word first, with the carry held in a
// register between words. Each word is held on the adder for SETTLE cycles
// before its sum and carry are captured.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : operand valid/ready in, result valid/ready out
//   busy                : high whenever the FSM is not IDLE
//   add_a, add_b        : current word presented to the adder
//   add_cin             : carry presented to the adder
//   add_sum, add_cout   : adder results, sampled at the end of each word
// -----------------------------------------------------------------------------
module cba_multiword_seq #(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 4,
   parameter int SETTLE    = 2
) (
   input  logic                clk,
   input  logic                rst,
   cba_multiword_seq_if.slave  bus,
   output logic                busy,
   output logic [WORD_W-1:0]   add_a,
   output logic [WORD_W-1:0]   add_b,
   output logic                add_cin,
   input  logic [WORD_W-1:0]   add_sum,
   input  logic                add_cout
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef logic [NUM_WORDS-1:0][WORD_W-1:0] words_t;

   state_t           state;
   words_t           a_reg;
   words_t           b_reg;
   words_t           sum_reg;
   words_t           sum_merged;
   logic             carry_reg;
   logic [IDX_W-1:0] word_idx;
   logic [CNT_W-1:0] settle_cnt;

   logic accept;
   logic capture;
   logic last_word;

   // in_ready is high exactly in IDLE, so the accept condition needs only the state.
   assign accept    = (state == IDLE) && bus.in_valid;
   assign capture   = (state == RUN) && (settle_cnt == CNT_LAST);
   assign last_word = (word_idx == IDX_LAST);

   // Adder drive is decoded from registers only; outside RUN it is parked at zero.
   always_comb begin
      // NOTE: every output gets a default before the conditional, so no latch is inferred.
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_reg[word_idx];
         add_b   = b_reg[word_idx];
         add_cin = carry_reg;
      end
   end

   // Final result: words already captured plus the slice coming out of the adder now.
   always_comb begin
      sum_merged           = sum_reg;
      sum_merged[word_idx] = add_sum;
   end

   // NOTE: operand and partial-sum storage carries no reset; every word is written
   // in an operation before it is read, so resetting it would only cost logic.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= bus.in_a;
         b_reg <= bus.in_b;
      end
      if (capture) begin
         sum_reg[word_idx] <= add_sum;
      end
   end

   // Control FSM with registered handshake outputs.
   // NOTE: state is updated with non-blocking assignments so every register sees
   // the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bus.in_ready <= 1'b1;
         bus.out_valid <= 1'b0;
         busy         <= 1'b0;
         bus.out_sum  <= '0;
         bus.out_cout <= 1'b0;
         carry_reg    <= 1'b0;
         word_idx     <= '0;
         settle_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  carry_reg    <= bus.in_cin;
                  word_idx     <= '0;
                  settle_cnt   <= '0;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (settle_cnt == CNT_LAST) begin
                  carry_reg  <= add_cout;
                  settle_cnt <= '0;
                  if (last_word) begin
                     bus.out_sum   <= sum_merged;
                     bus.out_cout  <= add_cout;
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                  end
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               // Result and all outputs hold until the sink takes it.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cba_multiword_seq.sv
// -----------------------------------------------------------------------------
// tb_cba_multiword_seq
// Drives cba_multiword_seq with directed and random operand pairs. A behavioural
// adder slice with a propagation delay longer than one clock period stands in
// for the external carry-bypass adder. Expected results come from plain
// (W+1)-bit arithmetic, queued at accept and compared by a separate monitor.
// -----------------------------------------------------------------------------
module tb_cba_multiword_seq;

   localparam int WORD_W    = 16;
   localparam int NUM_WORDS = 4;
   localparam int SETTLE    = 2;
   localparam int W         = WORD_W * NUM_WORDS;
   // Clocks from the cycle in which the accept is presented to the first out_valid.
   localparam int LAT       = NUM_WORDS * SETTLE + 1;
   localparam int SPACING   = NUM_WORDS * SETTLE + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              busy;
   logic [WORD_W-1:0] add_a;
   logic [WORD_W-1:0] add_b;
   logic              add_cin;
   logic [WORD_W-1:0] add_sum;
   logic              add_cout;

   cba_multiword_seq_if #(.W(W)) bus ();

   cba_multiword_seq #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .SETTLE    (SETTLE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Adder slice: result appears 50 time units after its inputs change, i.e.
   // after more than one 40-unit clock period but before SETTLE periods.
   assign #50 {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_cin};

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [W:0] exp_q[$];
   int         acc_q[$];
   bit         rand_ready = 1'b0;
   bit         ready_force = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference: full-width sum with carry, modulo 2^(W+1).
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   endfunction

   // Carry into word w: carry out of the sum of the w lower words.
   function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input int w);
      logic [W:0] mask;
      logic [W:0] s;
      mask = ({{W{1'b0}}, 1'b1} << (WORD_W * w)) - 1'b1;
      s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, cin};
      return s[WORD_W * w];
   endfunction

   // out_ready driver: forced level in directed tests, random in the soak test.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit         prev_ov;
      int         t;
      logic [W:0] e;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
         end else begin
            if (bus.in_valid && bus.in_ready) begin
               exp_q.push_back(ref_add(bus.in_a, bus.in_b, bus.in_cin));
               acc_q.push_back(cyc);
            end
            if (bus.out_valid && !prev_ov) begin
               if (acc_q.size() == 0) fail("out_valid_without_accept");
               else begin
                  t = acc_q.pop_front();
                  check("latency", cyc - t, LAT);
               end
            end
            if (bus.out_valid) begin
               check("in_ready_low_in_done", bus.in_ready, 1'b0);
               check("busy_in_done", busy, 1'b1);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) fail("unexpected_result");
               else begin
                  e = exp_q.pop_front();
                  check("result", {bus.out_cout, bus.out_sum}, e);
               end
            end
            prev_ov = bus.out_valid;
         end
      end
   end

   // Present operands at posedge+1 and hold until accepted; returns the cycle
   // number of the negedge at which in_ready was seen.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output int acc);
      int n;
      n   = 0;
      acc = -1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      while (acc < 0 && n < 100) begin
         @(negedge clk);
         n++;
         if (bus.in_ready) acc = cyc;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      // Scramble the operand lines: only the accept-edge values may matter.
      bus.in_a   = ~a;
      bus.in_b   = ~b;
      bus.in_cin = ~cin;
      if (acc < 0) fail("send_timeout");
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) fail("drain_timeout");
   endtask

   function automatic logic [W-1:0] rand_w();
      return {$urandom, $urandom};
   endfunction

   initial begin
      #4000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int         acc, acc1, acc2, acc3;
      logic [W-1:0] a, b;
      logic         cin;
      logic [W:0]   e;

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_cin   = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_sum", bus.out_sum, '0);
      check("rst_out_cout", bus.out_cout, 1'b0);
      check("rst_add", {add_a, add_b, add_cin}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: carry ripples through every word.
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, acc);
      drain();

      // 2: all-ones intermediate plus cin.
      send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, acc);
      drain();

      // 3: per-word carry and adder drive.
      a = 64'h0000_FFFF_0000_FFFF;
      b = 64'h1;
      send(a, b, 1'b0, acc);
      for (int w = 0; w < NUM_WORDS; w++) begin
         repeat (SETTLE) @(negedge clk);
         check($sformatf("add_cin_w%0d", w), add_cin, carry_into(a, b, 1'b0, w));
         check($sformatf("add_a_w%0d", w), add_a, a[w*WORD_W +: WORD_W]);
         check($sformatf("add_b_w%0d", w), add_b, b[w*WORD_W +: WORD_W]);
      end
      @(posedge clk);
      #1;
      drain();

      // 4: backpressure in DONE with in_valid asserted.
      ready_force = 1'b0;
      a   = rand_w();
      b   = rand_w();
      cin = 1'(($urandom));
      e   = ref_add(a, b, cin);
      send(a, b, cin, acc);
      begin
         int n;
         n = 0;
         while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (n >= 50) fail("done_timeout");
      end
      bus.in_a     = rand_w();
      bus.in_b     = rand_w();
      bus.in_cin   = 1'b1;
      bus.in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", bus.out_valid, 1'b1);
         check("bp_hold_result", {bus.out_cout, bus.out_sum}, e);
         check("bp_in_ready", bus.in_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      ready_force  = 1'b1;
      drain();
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("bp_not_consumed", {busy, bus.out_valid}, 2'b00);
      @(posedge clk);
      #1;

      // Back-to-back accepts with an always-ready sink.
      send(rand_w(), rand_w(), 1'b0, acc1);
      send(rand_w(), rand_w(), 1'b1, acc2);
      send(rand_w(), rand_w(), 1'b0, acc3);
      check("spacing_1", acc2 - acc1, SPACING);
      check("spacing_2", acc3 - acc2, SPACING);
      drain();

      // 5: reset during word 2 of RUN.
      send(rand_w(), rand_w(), 1'b1, acc);
      repeat (2 * SETTLE) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", bus.in_ready, 1'b1);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_add", {add_a, add_b, add_cin}, '0);
      @(posedge clk);
      #1;
      send(64'd5, 64'd7, 1'b0, acc);
      drain();

      // 6: random soak with gaps and random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         case ($urandom_range(0, 3))
            0: begin a = rand_w();        b = rand_w();                 end
            1: begin a = '1;              b = W'($urandom_range(0, 3)); end
            2: begin a = rand_w();        b = ~a;                       end
            default: begin
               a = rand_w();
               b = rand_w();
               a[WORD_W*($urandom_range(0, NUM_WORDS-1)) +: WORD_W] = '1;
            end
         endcase
         send(a, b, 1'(($urandom)), acc);
      end
      drain();
      rand_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
